// File: rtl/ddr4_rx_bitslip_align.sv
// Receive word aligner: slips the input IOD until PATTERN is seen MATCH_COUNT times in a row,
// then flags lock, passes data through and counts post-lock word errors (saturating).
module ddr4_rx_bitslip_align #(
  parameter logic [3:0] PATTERN     = 4'b0011,
  parameter int         MATCH_COUNT = 16,
  parameter int         SLIP_WAIT   = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       START,
  input  logic [3:0] RX_DATA_0,
  output logic       RX_BIT_SLIP,
  output logic       BUSY,
  output logic       LOCKED,
  output logic       FAIL,
  output logic [1:0] SLIP_CNT,
  output logic [7:0] ERR_CNT,
  output logic [3:0] DATA_OUT,
  output logic       DATA_VALID
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SLIP, S_WAIT, S_LOCKED, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    slip_cnt_d;
  logic [7:0]    err_cnt_d;
  logic          slip_pulse_d;
  logic          hit;

  assign hit = (RX_DATA_0 == PATTERN);

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    wait_d       = wait_q;
    slip_cnt_d   = SLIP_CNT;
    err_cnt_d    = ERR_CNT;
    slip_pulse_d = 1'b0;
    case (state_q)
      S_IDLE, S_LOCKED, S_FAIL: begin
        if (START) begin
          state_d    = S_CHECK;
          match_d    = '0;
          slip_cnt_d = 2'd0;
          err_cnt_d  = 8'd0;
        end else if (state_q == S_LOCKED && !hit && ERR_CNT != 8'hFF) begin
          err_cnt_d = ERR_CNT + 8'd1;
        end
      end
      S_CHECK: begin
        if (hit) begin
          match_d = match_q + MW'(1);
          if (match_q == MW'(MATCH_COUNT - 1)) state_d = S_LOCKED;
        end else if (SLIP_CNT != 2'd3) begin
          state_d = S_SLIP;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_SLIP: begin
        // Pulse is registered on the way out of SLIP, so it lands one cycle after the mismatch edge.
        slip_pulse_d = 1'b1;
        slip_cnt_d   = SLIP_CNT + 2'd1;
        wait_d       = WW'(SLIP_WAIT - 1);
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_CHECK;
          match_d = '0;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q     <= S_IDLE;
      match_q     <= '0;
      wait_q      <= '0;
      SLIP_CNT    <= 2'd0;
      ERR_CNT     <= 8'd0;
      RX_BIT_SLIP <= 1'b0;
      BUSY        <= 1'b0;
      LOCKED      <= 1'b0;
      FAIL        <= 1'b0;
      DATA_VALID  <= 1'b0;
      DATA_OUT    <= 4'd0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      wait_q      <= wait_d;
      SLIP_CNT    <= slip_cnt_d;
      ERR_CNT     <= err_cnt_d;
      RX_BIT_SLIP <= slip_pulse_d;
      BUSY        <= (state_d == S_CHECK) || (state_d == S_SLIP) || (state_d == S_WAIT);
      LOCKED      <= (state_d == S_LOCKED);
      FAIL        <= (state_d == S_FAIL);
      DATA_VALID  <= (state_d == S_LOCKED);
      DATA_OUT    <= RX_DATA_0;
    end
  end

endmodule

// File: tb/tb_ddr4_rx_bitslip_align.sv
// Directed bench for ddr4_rx_bitslip_align with default parameters (PATTERN 0011, 16 matches, wait 4).
module tb_ddr4_rx_bitslip_align;

  localparam int SW = 4;

  logic       FAB_CLK, ARST, START;
  logic [3:0] RX_DATA_0;
  logic       RX_BIT_SLIP, BUSY, LOCKED, FAIL, DATA_VALID;
  logic [1:0] SLIP_CNT;
  logic [7:0] ERR_CNT;
  logic [3:0] DATA_OUT;

  int errors = 0;
  int checks = 0;

  ddr4_rx_bitslip_align dut (
    .FAB_CLK(FAB_CLK), .ARST(ARST), .START(START), .RX_DATA_0(RX_DATA_0),
    .RX_BIT_SLIP(RX_BIT_SLIP), .BUSY(BUSY), .LOCKED(LOCKED), .FAIL(FAIL),
    .SLIP_CNT(SLIP_CNT), .ERR_CNT(ERR_CNT), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  function automatic logic [18:0] outs();
    return {RX_BIT_SLIP, BUSY, LOCKED, FAIL, SLIP_CNT, ERR_CNT, DATA_OUT, DATA_VALID};
  endfunction

  task automatic step();
    @(posedge FAB_CLK);
    @(negedge FAB_CLK);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge FAB_CLK);
    ARST  = 1'b1;
    START = 1'b0;
    step();
    ARST = 1'b0;
  endtask

  task automatic test_reset();
    ARST = 1'b1; START = 1'b0; RX_DATA_0 = 4'b0101;
    repeat (2) @(negedge FAB_CLK);
    checks++;
    if (outs() !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", outs());
    end
    ARST = 1'b0;
  endtask

  task automatic test_data_out();
    RX_DATA_0 = 4'b1010;
    step();
    checks++;
    if (DATA_OUT !== 4'b1010) begin
      errors++; $display("FAIL data_out_a: got %b want 1010", DATA_OUT);
    end
    RX_DATA_0 = 4'b0110;
    step();
    checks++;
    if (DATA_OUT !== 4'b0110 || BUSY !== 1'b0) begin
      errors++; $display("FAIL data_out_b: got %b busy %b want 0110 busy 0", DATA_OUT, BUSY);
    end
  endtask

  task automatic test_aligned();
    logic saw_slip, busy_drop;
    apply_reset();
    RX_DATA_0 = 4'b0011;
    pulse_start();
    checks++;
    if (BUSY !== 1'b1 || LOCKED !== 1'b0) begin
      errors++; $display("FAIL aligned_e0: busy %b locked %b want 1 0", BUSY, LOCKED);
    end
    saw_slip = 1'b0; busy_drop = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (RX_BIT_SLIP) saw_slip = 1'b1;
      if (k < 16 && (BUSY !== 1'b1 || LOCKED !== 1'b0)) busy_drop = 1'b1;
    end
    checks++;
    if (busy_drop) begin
      errors++; $display("FAIL aligned_busy: got early drop want busy through E16");
    end
    checks++;
    if (LOCKED !== 1'b1 || DATA_VALID !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL aligned_lock: locked %b valid %b busy %b want 1 1 0", LOCKED, DATA_VALID, BUSY);
    end
    checks++;
    if (SLIP_CNT !== 2'd0 || saw_slip !== 1'b0) begin
      errors++; $display("FAIL aligned_noslip: slip_cnt %0d saw_slip %b want 0 0", SLIP_CNT, saw_slip);
    end
  endtask

  task automatic test_post_lock_errors();
    RX_DATA_0 = 4'b0000;
    repeat (3) step();
    checks++;
    if (ERR_CNT !== 8'd3 || LOCKED !== 1'b1) begin
      errors++; $display("FAIL err_cnt_3: got %0d locked %b want 3 1", ERR_CNT, LOCKED);
    end
    repeat (251) step();
    checks++;
    if (ERR_CNT !== 8'd254) begin
      errors++; $display("FAIL err_cnt_254: got %0d want 254", ERR_CNT);
    end
    repeat (49) step();
    checks++;
    if (ERR_CNT !== 8'd255 || LOCKED !== 1'b1) begin
      errors++; $display("FAIL err_cnt_sat: got %0d locked %b want 255 1", ERR_CNT, LOCKED);
    end
    RX_DATA_0 = 4'b0011;
    pulse_start();
    checks++;
    if (LOCKED !== 1'b0 || DATA_VALID !== 1'b0 || ERR_CNT !== 8'd0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL restart_from_lock: locked %b valid %b err %0d busy %b want 0 0 0 1",
                         LOCKED, DATA_VALID, ERR_CNT, BUSY);
    end
  endtask

  task automatic test_rotated();
    logic [3:0] word;
    int pulses, countdown, lock_cyc;
    apply_reset();
    word = 4'b1100; RX_DATA_0 = word;
    pulse_start();
    pulses = 0; countdown = 0; lock_cyc = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      step();
      if (RX_BIT_SLIP) begin
        pulses++; countdown = SW;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          word = {word[2:0], word[3]};
          RX_DATA_0 = word;
        end
      end
      if (LOCKED) begin
        lock_cyc = cyc; break;
      end
    end
    checks++;
    if (lock_cyc !== 28) begin
      errors++; $display("FAIL rotated_lock_cycle: got %0d want 28", lock_cyc);
    end
    checks++;
    if (pulses !== 2 || SLIP_CNT !== 2'd2) begin
      errors++; $display("FAIL rotated_slips: pulses %0d slip_cnt %0d want 2 2", pulses, SLIP_CNT);
    end
  endtask

  task automatic test_never_aligns();
    int pcyc[3];
    int pulses, fail_cyc;
    apply_reset();
    RX_DATA_0 = 4'b0000;
    pulse_start();
    pulses = 0; fail_cyc = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      step();
      if (RX_BIT_SLIP) begin
        if (pulses < 3) pcyc[pulses] = cyc;
        pulses++;
      end
      if (FAIL) begin
        fail_cyc = cyc; break;
      end
    end
    checks++;
    if (pulses !== 3 || pcyc[0] !== 2 || pcyc[1] !== 8 || pcyc[2] !== 14) begin
      errors++; $display("FAIL noalign_pulses: count %0d at %0d %0d %0d want 3 at 2 8 14",
                         pulses, pcyc[0], pcyc[1], pcyc[2]);
    end
    checks++;
    if (fail_cyc !== 19 || SLIP_CNT !== 2'd3 || LOCKED !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL noalign_end: cycle %0d slip_cnt %0d locked %b busy %b want 19 3 0 0",
                         fail_cyc, SLIP_CNT, LOCKED, BUSY);
    end
    pulse_start();
    checks++;
    if (FAIL !== 1'b0 || BUSY !== 1'b1 || SLIP_CNT !== 2'd0) begin
      errors++; $display("FAIL noalign_restart: fail %b busy %b slip_cnt %0d want 0 1 0", FAIL, BUSY, SLIP_CNT);
    end
  endtask

  task automatic test_broken_run();
    int pulses, lock_cyc;
    apply_reset();
    RX_DATA_0 = 4'b0011;
    pulse_start();
    pulses = 0; lock_cyc = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      RX_DATA_0 = (cyc == 10) ? 4'b0000 : 4'b0011;
      step();
      if (RX_BIT_SLIP) pulses++;
      if (LOCKED) begin
        lock_cyc = cyc; break;
      end
    end
    checks++;
    if (lock_cyc !== 31 || pulses !== 1 || SLIP_CNT !== 2'd1) begin
      errors++; $display("FAIL broken_run: lock cycle %0d pulses %0d slip_cnt %0d want 31 1 1",
                         lock_cyc, pulses, SLIP_CNT);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    RX_DATA_0 = 4'b0000;
    pulse_start();
    step(); step();
    checks++;
    if (RX_BIT_SLIP !== 1'b1) begin
      errors++; $display("FAIL mid_pulse_setup: slip %b want 1", RX_BIT_SLIP);
    end
    ARST = 1'b1;
    #1;
    checks++;
    if (outs() !== 19'd0) begin
      errors++; $display("FAIL reset_during_slip: got %h want 0", outs());
    end
    step();
    ARST = 1'b0;
    pulse_start();
    step(); step();
    RX_DATA_0 = 4'b0110;
    step();
    checks++;
    if (BUSY !== 1'b1 || DATA_OUT !== 4'b0110 || SLIP_CNT !== 2'd1) begin
      errors++; $display("FAIL mid_wait_setup: busy %b data %b slip_cnt %0d want 1 0110 1", BUSY, DATA_OUT, SLIP_CNT);
    end
    ARST = 1'b1;
    #1;
    checks++;
    if (outs() !== 19'd0) begin
      errors++; $display("FAIL reset_during_wait: got %h want 0", outs());
    end
    step();
    ARST = 1'b0;
    RX_DATA_0 = 4'b0011;
    pulse_start();
    repeat (16) step();
    checks++;
    if (LOCKED !== 1'b1 || SLIP_CNT !== 2'd0) begin
      errors++; $display("FAIL realign_after_reset: locked %b slip_cnt %0d want 1 0", LOCKED, SLIP_CNT);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_data_out();
    test_aligned();
    test_post_lock_errors();
    test_rotated();
    test_never_aligns();
    test_broken_run();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
